// File: rtl/trafparser_l3_sched.sv
// L3 front-end scheduler: skips up to two VLAN tags, classifies IPv4/IPv6/other and
// delays the stream 3 words so per-packet attributes cover SOP..EOP. Option: TRAFPARSER_QINQ_EN.
module trafparser_l3_sched #(
    parameter int DELAY_P          = 3,
    parameter int RES_FIFO_DEPTH_P = 4
) (
    input  logic        clk_i,
    input  logic        srst_n_i,
    input  logic [63:0] pkt_data_i,
    input  logic [2:0]  pkt_mod_i,
    input  logic        pkt_sop_i,
    input  logic        pkt_eop_i,
    input  logic        pkt_en_i,
    output logic [63:0] pkt_data_o,
    output logic [2:0]  pkt_mod_o,
    output logic        pkt_sop_o,
    output logic        pkt_eop_o,
    output logic        pkt_en_o,
    output logic        ipv4_en_o,
    output logic        ipv6_en_o,
    output logic        ip_6b_n2b_start_o,
    output logic [1:0]  vlan_cnt_o,
    output logic [1:0]  l3_type_o
);
    localparam int PW = $clog2(RES_FIFO_DEPTH_P);
    localparam logic [15:0] ET_IPV4 = 16'h0800;
    localparam logic [15:0] ET_IPV6 = 16'h86DD;
    localparam logic [15:0] TPID_C  = 16'h8100;
    localparam logic [PW:0]   PTR_ONE = 1;
    localparam logic [PW:0]   PTR_TWO = 2;
    localparam logic [PW-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {L3_OTHER = 2'd0, L3_IPV4 = 2'd1, L3_IPV6 = 2'd2} l3_type_e;
    typedef enum logic [1:0] {ST_IDLE, ST_W1, ST_W2, ST_DONE} state_e;

    typedef struct packed {
        l3_type_e   l3_type;
        logic       align_6b;
        logic [1:0] vlan;
    } res_t;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  mod;
        logic        sop;
        logic        eop;
        logic        valid;
    } stage_t;

    localparam res_t RES_OTHER = '{l3_type: L3_OTHER, align_6b: 1'b1, vlan: 2'd0};

    function automatic logic is_outer_tpid(input logic [15:0] et);
`ifdef TRAFPARSER_QINQ_EN
        return (et == TPID_C) || (et == 16'h88A8) || (et == 16'h9100);
`else
        return et == TPID_C;
`endif
    endfunction

    stage_t      stg_q [DELAY_P];
    res_t        res_mem_q [RES_FIFO_DEPTH_P];
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    state_e      state_q;
    res_t        attr_q, out_rec, dec_rec, head;
    logic        drain, shift, out_vld, dec_hit, in_hdr;
    logic [15:0] et_lo, et_hi;
    logic [PW-1:0] wr_idx, wr_idx1;

    // Trailing words keep moving while any EOP is still buffered.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        drain = 1'b0;
        for (int i = 0; i < DELAY_P; i++) drain = drain | (stg_q[i].valid & stg_q[i].eop);
    end

    assign shift   = pkt_en_i | drain;
    assign out_vld = shift & stg_q[DELAY_P-1].valid;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            for (int i = 0; i < DELAY_P; i++) stg_q[i] <= '0;
        end else if (shift) begin
            // NOTE: non-blocking so each stage takes its neighbour's old value.
            stg_q[0] <= '{data: pkt_data_i, mod: pkt_mod_i, sop: pkt_sop_i,
                          eop: pkt_eop_i, valid: pkt_en_i};
            for (int i = 1; i < DELAY_P; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign et_lo   = pkt_data_i[31:16];
    assign et_hi   = pkt_data_i[63:48];
    assign in_hdr  = (state_q == ST_W1) || (state_q == ST_W2);
    assign wr_idx  = wr_ptr_q[PW-1:0];
    assign wr_idx1 = wr_idx + IDX_ONE;

    always_comb begin
        dec_hit = 1'b0;
        dec_rec = RES_OTHER;
        case (state_q)
            ST_W1: begin
                if (et_lo == ET_IPV4) begin
                    dec_hit = 1'b1;
                    dec_rec = '{L3_IPV4, 1'b1, 2'd0};
                end else if (et_lo == ET_IPV6) begin
                    dec_hit = 1'b1;
                    dec_rec = '{L3_IPV6, 1'b1, 2'd0};
                end else if (!is_outer_tpid(et_lo)) begin
                    dec_hit = 1'b1;
                end
            end
            ST_W2: begin
                dec_hit = 1'b1;
                if (et_hi == ET_IPV4)      dec_rec = '{L3_IPV4, 1'b0, 2'd1};
                else if (et_hi == ET_IPV6) dec_rec = '{L3_IPV6, 1'b0, 2'd1};
                else if (et_hi == TPID_C) begin
                    if (et_lo == ET_IPV4)      dec_rec = '{L3_IPV4, 1'b1, 2'd2};
                    else if (et_lo == ET_IPV6) dec_rec = '{L3_IPV6, 1'b1, 2'd2};
                    else                       dec_rec = '{L3_OTHER, 1'b1, 2'd2};
                end else begin
                    dec_rec = '{L3_OTHER, 1'b0, 2'd1};
                end
            end
            default: ;
        endcase
    end

    // A SOP that aborts an undecided header and is itself a 1-word packet needs two records.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
        end else if (pkt_en_i) begin
            if (pkt_sop_i) begin
                if (in_hdr && pkt_eop_i) begin
                    res_mem_q[wr_idx]  <= RES_OTHER;
                    res_mem_q[wr_idx1] <= RES_OTHER;
                    wr_ptr_q           <= wr_ptr_q + PTR_TWO;
                end else if (in_hdr || pkt_eop_i) begin
                    res_mem_q[wr_idx]  <= RES_OTHER;
                    wr_ptr_q           <= wr_ptr_q + PTR_ONE;
                end
                state_q <= pkt_eop_i ? ST_IDLE : ST_W1;
            end else begin
                case (state_q)
                    ST_W1, ST_W2: begin
                        if (dec_hit || pkt_eop_i) begin
                            res_mem_q[wr_idx] <= dec_hit ? dec_rec : RES_OTHER;
                            wr_ptr_q          <= wr_ptr_q + PTR_ONE;
                            state_q           <= pkt_eop_i ? ST_IDLE : ST_DONE;
                        end else begin
                            state_q <= ST_W2;
                        end
                    end
                    ST_DONE: if (pkt_eop_i) state_q <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the record memory is not reset; the pointers alone define which entries are live.
    assign head = res_mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            rd_ptr_q <= '0;
            attr_q   <= '0;
        end else if (out_vld) begin
            if (stg_q[DELAY_P-1].sop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (stg_q[DELAY_P-1].eop)      attr_q <= '0;
            else if (stg_q[DELAY_P-1].sop) attr_q <= head;
        end
    end

    // The SOP word shows the popped record directly so attributes line up with sop_o.
    assign out_rec = (out_vld && stg_q[DELAY_P-1].sop) ? head : attr_q;

    assign pkt_en_o          = out_vld;
    assign pkt_data_o        = out_vld ? stg_q[DELAY_P-1].data : '0;
    assign pkt_mod_o         = out_vld ? stg_q[DELAY_P-1].mod  : '0;
    assign pkt_sop_o         = out_vld & stg_q[DELAY_P-1].sop;
    assign pkt_eop_o         = out_vld & stg_q[DELAY_P-1].eop;
    assign ipv4_en_o         = (out_rec.l3_type == L3_IPV4);
    assign ipv6_en_o         = (out_rec.l3_type == L3_IPV6);
    assign ip_6b_n2b_start_o = out_rec.align_6b;
    assign vlan_cnt_o        = out_rec.vlan;
    assign l3_type_o         = out_rec.l3_type;
endmodule

// File: tb/tb_trafparser_l3_sched.sv
// Scoreboard bench for trafparser_l3_sched: expected words and per-packet attributes are
// queued as stimulus is driven and compared as words leave the DUT.
module tb_trafparser_l3_sched;
    logic        clk_i = 1'b0;
    logic        srst_n_i;
    logic [63:0] pkt_data_i;
    logic [2:0]  pkt_mod_i;
    logic        pkt_sop_i, pkt_eop_i, pkt_en_i;
    logic [63:0] pkt_data_o;
    logic [2:0]  pkt_mod_o;
    logic        pkt_sop_o, pkt_eop_o, pkt_en_o;
    logic        ipv4_en_o, ipv6_en_o, ip_6b_n2b_start_o;
    logic [1:0]  vlan_cnt_o, l3_type_o;

    trafparser_l3_sched dut (
        .clk_i(clk_i), .srst_n_i(srst_n_i),
        .pkt_data_i(pkt_data_i), .pkt_mod_i(pkt_mod_i), .pkt_sop_i(pkt_sop_i),
        .pkt_eop_i(pkt_eop_i), .pkt_en_i(pkt_en_i),
        .pkt_data_o(pkt_data_o), .pkt_mod_o(pkt_mod_o), .pkt_sop_o(pkt_sop_o),
        .pkt_eop_o(pkt_eop_o), .pkt_en_o(pkt_en_o),
        .ipv4_en_o(ipv4_en_o), .ipv6_en_o(ipv6_en_o),
        .ip_6b_n2b_start_o(ip_6b_n2b_start_o), .vlan_cnt_o(vlan_cnt_o), .l3_type_o(l3_type_o)
    );

    always #5 clk_i = ~clk_i;

    // Attribute vector: {ipv4_en, ipv6_en, align_6b, vlan[1:0], l3_type[1:0]}
    localparam logic [6:0] M_ALL        = 7'h7F;
    localparam logic [6:0] M_OTHER      = 7'b1100011;
    localparam logic [6:0] M_OTHER_VLAN = 7'b1100111;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  mod;
        logic        sop;
        logic        eop;
        logic [6:0]  attr;
        logic [6:0]  mask;
        int          in_cyc;
        bit          lat;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         in_pkt = 1'b0;
    logic [6:0] cur_attr = '0;
    logic [6:0] cur_mask = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] mk_attr(input logic [1:0] t, input logic a, input logic [1:0] v);
        return {t == 2'd1, t == 2'd2, a, v, t};
    endfunction

    task automatic drive_word(input logic [63:0] d, input logic [2:0] m, input logic s,
                              input logic e, input logic [6:0] attr, input logic [6:0] mask,
                              input bit lat);
        exp_t x;
        pkt_data_i = d; pkt_mod_i = m; pkt_sop_i = s; pkt_eop_i = e; pkt_en_i = 1'b1;
        x.data = d; x.mod = m; x.sop = s; x.eop = e;
        x.attr = attr; x.mask = mask; x.in_cyc = cyc; x.lat = lat;
        sb_q.push_back(x);
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        pkt_en_i = 1'b0; pkt_sop_i = 1'b0; pkt_eop_i = 1'b0;
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    // et_a sits at word1[31:16]; et_b/et_c at word2[63:48]/[31:16].
    task automatic send_pkt(input logic [15:0] et_a, input logic [15:0] et_b,
                            input logic [15:0] et_c, input int len, input logic [2:0] last_mod,
                            input logic [6:0] attr, input logic [6:0] mask, input bit lat,
                            input int gap);
        for (int i = 0; i < len; i++) begin
            logic [63:0] w;
            w = {$urandom, $urandom};
            if (i == 1) w[31:16] = et_a;
            if (i == 2) begin w[63:48] = et_b; w[31:16] = et_c; end
            drive_word(w, (i == len - 1) ? last_mod : 3'd0, i == 0, i == len - 1, attr, mask, lat);
            if (gap > 0 && i != len - 1) idle(gap);
        end
    endtask

    always @(negedge clk_i) begin
        if (srst_n_i) begin
            logic [6:0] a;
            a = {ipv4_en_o, ipv6_en_o, ip_6b_n2b_start_o, vlan_cnt_o, l3_type_o};
            if (pkt_en_o) begin
                if (sb_q.size() == 0) begin
                    check("spurious_en", pkt_en_o, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("data", pkt_data_o, e.data);
                    check("ctl", {pkt_mod_o, pkt_sop_o, pkt_eop_o}, {e.mod, e.sop, e.eop});
                    check("attr", a & e.mask, e.attr & e.mask);
                    if (e.lat) check("latency", cyc - e.in_cyc, 3);
                    if (e.sop) begin in_pkt = 1'b1; cur_attr = e.attr; cur_mask = e.mask; end
                    if (e.eop) in_pkt = 1'b0;
                end
            end else if (in_pkt) begin
                check("attr_hold", a & cur_mask, cur_attr & cur_mask);
            end else begin
                check("attr_idle", a, 7'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst_n_i = 1'b0;
        pkt_data_i = '0; pkt_mod_i = '0; pkt_sop_i = 1'b0; pkt_eop_i = 1'b0; pkt_en_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 srst_n_i = 1'b1;
        @(negedge clk_i);
        check("reset_en", pkt_en_o, 1'b0);
        check("reset_out", {pkt_data_o, pkt_mod_o, pkt_sop_o, pkt_eop_o}, '0);
        @(posedge clk_i); #1;

        // Untagged IPv4, 8 words
        send_pkt(16'h0800, 16'h0, 16'h0, 8, 3'd4, mk_attr(2'd1, 1'b1, 2'd0), M_ALL, 1'b1, 0);
        idle(6);
        // Single tag: IPv6 and IPv4 behind 0x8100
        send_pkt(16'h8100, 16'h86DD, 16'h0, 6, 3'd0, mk_attr(2'd2, 1'b0, 2'd1), M_ALL, 1'b1, 0);
        idle(5);
        send_pkt(16'h8100, 16'h0800, 16'h0, 4, 3'd2, mk_attr(2'd1, 1'b0, 2'd1), M_ALL, 1'b1, 0);
        idle(5);
        // S-tag outer: only accepted with QinQ support
`ifdef TRAFPARSER_QINQ_EN
        send_pkt(16'h88A8, 16'h8100, 16'h0800, 5, 3'd0, mk_attr(2'd1, 1'b1, 2'd2), M_ALL, 1'b1, 0);
`else
        send_pkt(16'h88A8, 16'h8100, 16'h0800, 5, 3'd0, mk_attr(2'd0, 1'b0, 2'd0), M_OTHER, 1'b1, 0);
`endif
        idle(5);
        // Double C-tag variants, third tag, unknown inner ethertype
        send_pkt(16'h8100, 16'h8100, 16'h86DD, 5, 3'd7, mk_attr(2'd2, 1'b1, 2'd2), M_ALL, 1'b1, 0);
        send_pkt(16'h8100, 16'h8100, 16'h8100, 4, 3'd0, mk_attr(2'd0, 1'b0, 2'd2), M_OTHER_VLAN, 1'b1, 0);
        send_pkt(16'h8100, 16'h0806, 16'h0800, 4, 3'd0, mk_attr(2'd0, 1'b0, 2'd1), M_OTHER_VLAN, 1'b1, 0);
        idle(5);
        // Runt: tag seen, eop before any decision
        send_pkt(16'h8100, 16'h0, 16'h0, 2, 3'd6, mk_attr(2'd0, 1'b1, 2'd0), M_ALL, 1'b1, 0);
        idle(5);
        // 1-word packet back-to-back with untagged IPv6
        send_pkt(16'h0, 16'h0, 16'h0, 1, 3'd5, mk_attr(2'd0, 1'b0, 2'd0), M_OTHER, 1'b1, 0);
        send_pkt(16'h86DD, 16'h0, 16'h0, 5, 3'd3, mk_attr(2'd2, 1'b1, 2'd0), M_ALL, 1'b1, 0);
        idle(5);
        // Lone 1-word packet must drain with no further input
        send_pkt(16'h0, 16'h0, 16'h0, 1, 3'd1, mk_attr(2'd0, 1'b0, 2'd0), M_OTHER, 1'b1, 0);
        idle(6);
        // pkt_en_i toggling every cycle
        send_pkt(16'h0800, 16'h0, 16'h0, 8, 3'd0, mk_attr(2'd1, 1'b1, 2'd0), M_ALL, 1'b0, 1);
        idle(6);

        // Reset in the middle of a packet
        drive_word({$urandom, $urandom}, 3'd0, 1'b1, 1'b0, mk_attr(2'd1, 1'b1, 2'd0), M_ALL, 1'b0);
        drive_word({32'h0, 16'h0800, 16'h0}, 3'd0, 1'b0, 1'b0, mk_attr(2'd1, 1'b1, 2'd0), M_ALL, 1'b0);
        drive_word({$urandom, $urandom}, 3'd0, 1'b0, 1'b0, mk_attr(2'd1, 1'b1, 2'd0), M_ALL, 1'b0);
        pkt_en_i = 1'b0; pkt_sop_i = 1'b0; srst_n_i = 1'b0;
        @(posedge clk_i); #1;
        srst_n_i = 1'b1;
        sb_q.delete();
        in_pkt = 1'b0;
        @(negedge clk_i);
        check("midrst_en", pkt_en_o, 1'b0);
        check("midrst_attr", {ipv4_en_o, ipv6_en_o, ip_6b_n2b_start_o, vlan_cnt_o, l3_type_o}, '0);
        @(posedge clk_i); #1;
        idle(2);
        send_pkt(16'h0800, 16'h0, 16'h0, 6, 3'd0, mk_attr(2'd1, 1'b1, 2'd0), M_ALL, 1'b1, 0);
        idle(4);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk_i);
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
